// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Package  : xbar_pkg
// Purpose  : Shared crossbar definitions. Holds the TL-UL channel structs and
//            opcode enums, the device enumeration, the per-device
//            address-space/mask table and the error-responder state
//            encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package xbar_pkg;

  // --------------------------------------------------------------------------
  // TL-UL channel definitions
  // --------------------------------------------------------------------------
  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_SZW = 2;
  localparam int unsigned TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // --------------------------------------------------------------------------
  // Device address map
  // --------------------------------------------------------------------------
  localparam int unsigned N_DEVICE = 11;

  typedef enum logic [3:0] {
    TlIccm     = 4'd0,
    TlDccm     = 4'd1,
    TlGpio     = 4'd2,
    TlLdo1     = 4'd3,
    TlLdo2     = 4'd4,
    TlUart     = 4'd5,
    TlTimer    = 4'd6,
    TlSpi      = 4'd7,
    TlI2c      = 4'd8,
    TlPwm      = 4'd9,
    TlPeriCtrl = 4'd10
  } tl_device_e;

  localparam logic [31:0] ADDR_SPACE_ICCM      = 32'h0000_0000;
  localparam logic [31:0] ADDR_SPACE_DCCM      = 32'h1000_0000;
  localparam logic [31:0] ADDR_SPACE_GPIO      = 32'h4008_0000;
  localparam logic [31:0] ADDR_SPACE_LDO1      = 32'h4009_0000;
  localparam logic [31:0] ADDR_SPACE_LDO2      = 32'h400a_0000;
  localparam logic [31:0] ADDR_SPACE_UART      = 32'h4000_0000;
  localparam logic [31:0] ADDR_SPACE_TIMER     = 32'h4001_0000;
  localparam logic [31:0] ADDR_SPACE_SPI       = 32'h4002_0000;
  localparam logic [31:0] ADDR_SPACE_I2C       = 32'h4003_0000;
  localparam logic [31:0] ADDR_SPACE_PWM       = 32'h4004_0000;
  localparam logic [31:0] ADDR_SPACE_PERI_CTRL = 32'h4005_0000;

  localparam logic [31:0] ADDR_MASK_ICCM      = 32'h0001_ffff;
  localparam logic [31:0] ADDR_MASK_DCCM      = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_GPIO      = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_LDO1      = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_LDO2      = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_UART      = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_TIMER     = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_SPI       = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_I2C       = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_PWM       = 32'h0000_ffff;
  localparam logic [31:0] ADDR_MASK_PERI_CTRL = 32'h0000_ffff;

  // Element [i] belongs to device i, so the list runs from the highest index down.
  localparam logic [N_DEVICE-1:0][31:0] ADDR_SPACE = {
    ADDR_SPACE_PERI_CTRL, ADDR_SPACE_PWM, ADDR_SPACE_I2C, ADDR_SPACE_SPI,
    ADDR_SPACE_TIMER, ADDR_SPACE_UART, ADDR_SPACE_LDO2, ADDR_SPACE_LDO1,
    ADDR_SPACE_GPIO, ADDR_SPACE_DCCM, ADDR_SPACE_ICCM
  };

  localparam logic [N_DEVICE-1:0][31:0] ADDR_MASK = {
    ADDR_MASK_PERI_CTRL, ADDR_MASK_PWM, ADDR_MASK_I2C, ADDR_MASK_SPI,
    ADDR_MASK_TIMER, ADDR_MASK_UART, ADDR_MASK_LDO2, ADDR_MASK_LDO1,
    ADDR_MASK_GPIO, ADDR_MASK_DCCM, ADDR_MASK_ICCM
  };

  // --------------------------------------------------------------------------
  // Error responder state encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ErrIdle = 1'b0,
    ErrResp = 1'b1
  } err_state_e;

endpackage
`default_nettype wire

// File: rtl/xbar_err_resp.sv
`default_nettype none
// ============================================================================
// Module   : xbar_err_resp
// Purpose  : Answers requests that decode to no device. Accepts one request
//            at a time and returns a TL-UL error response the next cycle.
// Ports    : clk_i/rst_ni      clock, async active-low reset
//            a_valid_i/a_ready_o, a_opcode_i, a_source_i, a_size_i  request
//            d_valid_o/d_ready_i, d_opcode_o, d_source_o, d_size_o,
//            d_error_o, d_data_o                                    response
// Revision : 1.0 - initial release
// ============================================================================
module xbar_err_resp
  import xbar_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_valid_i,
  input  tl_a_op_e          a_opcode_i,
  input  logic [TL_AIW-1:0] a_source_i,
  input  logic [TL_SZW-1:0] a_size_i,
  output logic              a_ready_o,
  input  logic              d_ready_i,
  output logic              d_valid_o,
  output tl_d_op_e          d_opcode_o,
  output logic [TL_AIW-1:0] d_source_o,
  output logic [TL_SZW-1:0] d_size_o,
  output logic              d_error_o,
  output logic [TL_DW-1:0]  d_data_o
);

  err_state_e        state_q, state_d;
  tl_d_op_e          opcode_q, opcode_d;
  logic [TL_AIW-1:0] source_q, source_d;
  logic [TL_SZW-1:0] size_q, size_d;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    source_d = source_q;
    size_d   = size_q;
    unique case (state_q)
      ErrIdle: begin
        // a_ready is 1 in IDLE, so a_valid alone is the accept.
        if (a_valid_i) begin
          state_d  = ErrResp;
          opcode_d = (a_opcode_i == Get) ? AccessAckData : AccessAck;
          source_d = a_source_i;
          size_d   = a_size_i;
        end
      end
      ErrResp: begin
        if (d_ready_i) state_d = ErrIdle;
      end
      default: state_d = ErrIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ErrIdle;
      opcode_q <= AccessAck;
      source_q <= '0;
      size_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      source_q <= source_d;
      size_q   <= size_d;
    end
  end

  assign a_ready_o  = (state_q == ErrIdle);
  assign d_valid_o  = (state_q == ErrResp);
  assign d_opcode_o = opcode_q;
  assign d_source_o = source_q;
  assign d_size_o   = size_q;
  assign d_error_o  = (state_q == ErrResp);
  assign d_data_o   = (state_q == ErrResp) ? '1 : '0;

endmodule
`default_nettype wire

// File: rtl/xbar_steer_1n.sv
`default_nettype none
// ============================================================================
// Module   : xbar_steer_1n
// Purpose  : 1-to-N TL-UL steering socket. Decodes the host A-channel against
//            a base/mask table, forwards it to one device (or the internal
//            error responder) and muxes the selected D-channel back. All
//            outstanding requests go to a single target, so responses can
//            never reorder across devices.
// Ports    : clk_i/rst_ni  clock, async active-low reset
//            tl_h_i/tl_h_o host request / response
//            tl_d_o/tl_d_i per-device request / response (NDev each)
// Revision : 1.0 - initial release
// ============================================================================
module xbar_steer_1n
  import xbar_pkg::*;
#(
  parameter int unsigned           NDev           = N_DEVICE,
  parameter int unsigned           MaxOutstanding = 4,
  parameter logic [NDev-1:0][31:0] DevBase        = ADDR_SPACE,
  parameter logic [NDev-1:0][31:0] DevMask        = ADDR_MASK
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i,
  output tl_d2h_t tl_h_o,
  output tl_h2d_t tl_d_o [NDev],
  input  tl_d2h_t tl_d_i [NDev]
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned SelW = $clog2(NDev + 1);
  localparam logic [SelW-1:0] ErrSel = SelW'(NDev);

  // Overlapping entries are legal (lowest index wins) but almost always a
  // table mistake, so they are reported at elaboration.
  function automatic logic table_overlaps(input logic [NDev-1:0][31:0] base,
                                          input logic [NDev-1:0][31:0] mask);
    logic ov;
    ov = 1'b0;
    for (int i = 0; i < int'(NDev); i++) begin
      for (int j = i + 1; j < int'(NDev); j++) begin
        if (((base[i] ^ base[j]) & ~mask[i] & ~mask[j]) == 32'h0) ov = 1'b1;
      end
    end
    return ov;
  endfunction

  localparam logic TableOverlap = table_overlaps(DevBase, DevMask);

  if (TableOverlap) begin : g_overlap_warn
    $warning("xbar_steer_1n: overlapping address table entries, lowest index wins");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] dev_sel;
  logic            hold;
  logic            tgt_ready;
  logic            a_ready;
  logic            acc_evt;
  logic            rsp_evt;

  logic              err_a_valid;
  logic              err_a_ready;
  logic              err_d_ready;
  logic              err_d_valid;
  tl_d_op_e          err_d_opcode;
  logic [TL_AIW-1:0] err_d_source;
  logic [TL_SZW-1:0] err_d_size;
  logic              err_d_error;
  logic [TL_DW-1:0]  err_d_data;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    dev_sel = ErrSel;
    for (int i = int'(NDev) - 1; i >= 0; i--) begin
      if ((tl_h_i.a_address & ~DevMask[i]) == DevBase[i]) dev_sel = SelW'(i);
    end
  end

  // Stall when switching targets with traffic in flight, or when full.
  assign hold = ((cnt_q != '0) && (dev_sel != sel_q)) ||
                (cnt_q == CntW'(MaxOutstanding));

  always_comb begin
    tgt_ready = err_a_ready;
    for (int i = 0; i < int'(NDev); i++) begin
      if (dev_sel == SelW'(i)) tgt_ready = tl_d_i[i].a_ready;
    end
  end

  assign a_ready     = ~hold & tgt_ready;
  assign err_a_valid = tl_h_i.a_valid & ~hold & (dev_sel == ErrSel);
  assign err_d_ready = tl_h_i.d_ready & (sel_q == ErrSel);

  // A-channel: payload broadcast, a_valid steered. D-ready follows sel_q.
  always_comb begin
    for (int i = 0; i < int'(NDev); i++) begin
      tl_d_o[i]         = tl_h_i;
      tl_d_o[i].a_valid = tl_h_i.a_valid & ~hold & (dev_sel == SelW'(i));
      tl_d_o[i].d_ready = tl_h_i.d_ready & (sel_q == SelW'(i));
    end
  end

  // D-channel: only the in-flight target is visible to the host.
  always_comb begin
    tl_h_o = '0;
    if (sel_q == ErrSel) begin
      tl_h_o.d_valid  = err_d_valid;
      tl_h_o.d_opcode = err_d_opcode;
      tl_h_o.d_size   = err_d_size;
      tl_h_o.d_source = err_d_source;
      tl_h_o.d_data   = err_d_data;
      tl_h_o.d_error  = err_d_error;
    end
    for (int i = 0; i < int'(NDev); i++) begin
      if (sel_q == SelW'(i)) tl_h_o = tl_d_i[i];
    end
    tl_h_o.a_ready = a_ready;
  end

  assign acc_evt = tl_h_i.a_valid & a_ready;
  assign rsp_evt = tl_h_o.d_valid & tl_h_i.d_ready;

  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (acc_evt) sel_d = dev_sel;
    unique case ({acc_evt, rsp_evt})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  xbar_err_resp u_err_resp (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .a_valid_i  (err_a_valid),
    .a_opcode_i (tl_h_i.a_opcode),
    .a_source_i (tl_h_i.a_source),
    .a_size_i   (tl_h_i.a_size),
    .a_ready_o  (err_a_ready),
    .d_ready_i  (err_d_ready),
    .d_valid_o  (err_d_valid),
    .d_opcode_o (err_d_opcode),
    .d_source_o (err_d_source),
    .d_size_o   (err_d_size),
    .d_error_o  (err_d_error),
    .d_data_o   (err_d_data)
  );

`ifndef SYNTHESIS
  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(rsp_evt && (cnt_q == '0)));
  a_no_overflow  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    cnt_q <= CntW'(MaxOutstanding));
`endif

endmodule
`default_nettype wire

// File: doc/xbar_steer_1n.md
Name: xbar_steer_1n

Overview:
Parametrised 1-to-N TL-UL steering socket, the next generation of the fixed 11-device crossbar address map. It decodes one host A-channel against a per-device base/mask table and forwards the request to the selected device port. The device D-channel is muxed back to the host. It tracks outstanding transactions so responses can never reorder across devices, and it answers unmapped addresses from an internal error responder. One instance sits per host (ibex IF, ibex LSU) inside the crossbar.

Parameters:
NDev, 11, number of device ports (1..32)
MaxOutstanding, 4, maximum accepted-but-unanswered requests (1..15)
DevBase, xbar_pkg address-space table, NDev x 32-bit base addresses
DevMask, xbar_pkg address-mask table, NDev x 32-bit masks (ones = offset bits)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
tl_h_i  in  tl_h2d_t  host request (A-channel, d_ready)
tl_h_o  out  tl_d2h_t  host response (D-channel, a_ready)
tl_d_o  out  NDev x tl_h2d_t  device requests
tl_d_i  in  NDev x tl_d2h_t  device responses

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Decode (combinational):
  - dev_sel = lowest index i where (a_address & ~DevMask[i]) == DevBase[i].
  - If no index matches, dev_sel = NDev (error target).
- State registers:
  - outstanding count cnt, width $clog2(MaxOutstanding+1).
  - sel_q, the target of the in-flight transactions, width $clog2(NDev+1).
- Hold condition: hold = (cnt != 0 && dev_sel != sel_q) || cnt == MaxOutstanding.
- A-channel forwarding:
  - tl_d_o[i].a_valid = a_valid & ~hold & (dev_sel == i). All other A fields are broadcast to every device.
  - tl_h_o.a_ready = ~hold & ready of the target (device a_ready, or the error responder's ready).
- Accept and response events:
  - Accept = host a_valid & a_ready. On accept: cnt += 1 and sel_q <= dev_sel.
  - Response = tl_h_o.d_valid & host d_ready. On response: cnt -= 1.
  - Accept and response in the same cycle: cnt unchanged.
  - Response with cnt == 0: cnt stays 0 (assertion fires). cnt never exceeds MaxOutstanding (assertion).
- D-channel return:
  - tl_h_o D fields are muxed from sel_q.
  - tl_d_o[i].d_ready = host d_ready & (sel_q == i).
  - A device's d_valid is ignored while sel_q differs from that device.
- Error responder (sub-module), 2 states: IDLE and RESP.
  - IDLE: err_a_ready = 1. On accept it captures a_source and a_size and moves to RESP.
  - RESP: d_valid = 1, d_error = 1, d_data = 0xFFFFFFFF, d_source and d_size echoed.
  - Opcode: AccessAckData for Get, AccessAck for PutFull/PutPartial.
  - Returns to IDLE on d_ready. err_a_ready = 0 while in RESP.
  - Latency: the response appears the cycle after accept.
- Latency: 0 cycles A-path and D-path through the socket (pure mux). Only the state registers are clocked.
- Reset values: cnt = 0, sel_q = 0, error FSM = IDLE.
  - All tl_d_o a_valid = 0. tl_h_o d_valid = 0.
  - tl_h_o.a_ready = device 0 a_ready gated by decode.
  - Reset mid-transaction drops all tracking. Devices are reset on the same rst_ni.
- Overlapping table entries: lowest index wins. This is legal but flagged by an elaboration assertion.

Decomposition:
- xbar_pkg holds:
  - N_DEVICE, the ADDR_SPACE_*/ADDR_MASK_* constants, and tl_device_e.
  - DevBase/DevMask arrays packed as localparam logic [N_DEVICE-1:0][31:0].
  - TL opcode enum (shared with tlul_pkg).
- One sub-module, xbar_err_resp, contains the error responder FSM.

Test Plan:
- Get at 0x40080004, device 2 (GPIO) answers with data 0x1234 after 3 cycles -> only tl_d_o[2].a_valid asserted; host receives d_data 0x1234, d_error 0; cnt goes 0->1->0.
- Get to 0x40080000 (GPIO) outstanding, then Get to 0x40090000 (LDO1) -> a_ready = 0 and tl_d_o[3].a_valid = 0 until the GPIO response is taken; the LDO1 request is forwarded in the cycle cnt returns to 0.
- Five back-to-back Puts to 0x10000000 (DCCM) with DCCM d_valid held low -> four accepted, fifth stalled (cnt = 4). One response releases it.
- PutFull to unmapped 0x50000000, source 3 -> no device a_valid; the next cycle the host sees d_valid, d_error = 1, AccessAck, d_source 3. A second unmapped request stalls until d_ready.
- Accept and response in the same cycle with cnt = 2 -> cnt stays 2 and sel_q is unchanged.
- rst_ni asserted low while cnt = 3 and the error FSM is in RESP -> the next cycle cnt = 0, FSM IDLE, all d_valid/a_valid outputs 0. Post-reset traffic to 0x400a0000 is routed to device 4.
